// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scoreboard: forwarding selects and the
// per-unit writeback FSM state type.
package hazard_pkg;

   // Forwarding mux selects for the E-stage operands
   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   // Multi-cycle unit FSM state
   typedef logic [1:0] unit_state_t;
   localparam unit_state_t UNIT_IDLE = 2'd0;
   localparam unit_state_t UNIT_BUSY = 2'd1;
   localparam unit_state_t UNIT_WAIT = 2'd2;

   // M-stage result has priority over W-stage result
   function automatic logic [1:0] fwd_sel(input logic match_m, input logic match_w);
      if (match_m)      return FWD_M;
      else if (match_w) return FWD_W;
      else              return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_unit_fsm.sv
// Tracks one multi-cycle unit from dispatch to register-file writeback and
// remembers the destination register captured at dispatch.
module hazard_unit_fsm
   import hazard_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              done,
   input  logic              grant,
   input  logic [ADDR_W-1:0] wa_in,
   output unit_state_t       state,
   output logic [ADDR_W-1:0] wa
);

   unit_state_t       state_q, state_d;
   logic [ADDR_W-1:0] wa_q, wa_d;

   // Next state: dispatch -> BUSY; Done waits in WAIT until granted, or goes
   // straight back to IDLE when the grant arrives with Done
   always_comb begin
      state_d = state_q;
      wa_d    = wa_q;
      case (state_q)
         UNIT_IDLE: begin
            if (start) begin
               state_d = UNIT_BUSY;
               wa_d    = wa_in;
            end
         end
         UNIT_BUSY: begin
            if (done) state_d = grant ? UNIT_IDLE : UNIT_WAIT;
         end
         UNIT_WAIT: begin
            if (grant) state_d = UNIT_IDLE;
         end
         default: state_d = UNIT_IDLE;
      endcase
   end

   // State and destination register flops; reset discards any operation
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= UNIT_IDLE;
         wa_q    <= '0;
      end else begin
         state_q <= state_d;
         wa_q    <= wa_d;
      end
   end

   assign state = state_q;
   assign wa    = wa_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit with forwarding, load-use stall, and a register
// scoreboard for multi-cycle units sharing the single regfile write port.
// Optional performance counters: define HAZARD_SB_PERF_EN.
//
// Unit writeback handshake: a unit raises UnitDone[i] and holds it until it
// sees UnitGrant[i] high in the same cycle; the writeback transfers on that
// edge. UnitGrant is one-hot, only goes to a unit in BUSY/WAIT, and is
// withheld while the pipeline's own W stage writes (RegWriteW).
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 4,
   parameter int NUM_MCU  = 2
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [ADDR_W-1:0]   RA1D,
   input  logic [ADDR_W-1:0]   RA2D,
   input  logic [ADDR_W-1:0]   WA3D,
   input  logic [ADDR_W-1:0]   RA1E,
   input  logic [ADDR_W-1:0]   RA2E,
   input  logic [ADDR_W-1:0]   RA2M,
   input  logic [ADDR_W-1:0]   WA3E,
   input  logic [ADDR_W-1:0]   WA3M,
   input  logic [ADDR_W-1:0]   WA3W,
   input  logic                RegWriteD,
   input  logic                RegWriteE,
   input  logic                RegWriteM,
   input  logic                RegWriteW,
   input  logic                MemtoRegE,
   input  logic                MemtoRegW,
   input  logic                MemWriteM,
   input  logic                PCSrcE,
   input  logic                CacheStall,
   input  logic [NUM_MCU-1:0]  UnitStartD,
   input  logic [NUM_MCU-1:0]  UnitDone,
   output logic [NUM_MCU-1:0]  UnitGrant,
   output logic                UnitWbValid,
   output logic [ADDR_W-1:0]   UnitWbWA,
   output logic [1:0]          ForwardAE,
   output logic [1:0]          ForwardBE,
   output logic                ForwardM,
   output logic                StallF,
   output logic                StallD,
   output logic                StallE,
   output logic                StallM,
   output logic                FlushD,
   output logic                FlushE,
   output logic [NUM_REGS-1:0] SbPending,
   output logic [31:0]         StallCnt,
   output logic [31:0]         FlushCnt
);

   localparam int OWN_W = (NUM_MCU > 1) ? $clog2(NUM_MCU) : 1;

   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [OWN_W-1:0]    owner_q [NUM_REGS];
   logic [OWN_W-1:0]    owner_d [NUM_REGS];

   unit_state_t         unit_state [NUM_MCU];
   logic [ADDR_W-1:0]   unit_wa    [NUM_MCU];
   logic [NUM_MCU-1:0]  unit_busy;
   logic [NUM_MCU-1:0]  unit_start;
   logic [NUM_MCU-1:0]  start_sel;
   logic [OWN_W-1:0]    start_idx;
   logic [NUM_MCU-1:0]  grant_vec;
   logic [OWN_W-1:0]    grant_idx;
   logic [ADDR_W-1:0]   wb_wa;
   logic                ldrstall, sbstall, dispatch_ok;

   // Out-of-range addresses (when 2**ADDR_W > NUM_REGS) are never pending
   function automatic logic pend_rd(input logic [NUM_REGS-1:0] p, input logic [ADDR_W-1:0] a);
      return (int'(a) < NUM_REGS) ? p[a] : 1'b0;
   endfunction

   // Forwarding selects and store-data forward
   always_comb begin
      ForwardAE = fwd_sel((RA1E == WA3M) && RegWriteM, (RA1E == WA3W) && RegWriteW);
      ForwardBE = fwd_sel((RA2E == WA3M) && RegWriteM, (RA2E == WA3W) && RegWriteW);
      ForwardM  = (RA2M == WA3W) && MemWriteM && MemtoRegW && RegWriteW;
   end

   // Lowest-index dispatch request wins
   always_comb begin
      start_sel = '0;
      start_idx = '0;
      for (int i = 0; i < NUM_MCU; i++) begin
         if (UnitStartD[i] && (start_sel == '0)) begin
            start_sel[i] = 1'b1;
            start_idx    = OWN_W'(i);
         end
      end
   end

   // Writeback arbiter: lowest active unit with Done, none while W writes
   always_comb begin
      grant_vec = '0;
      grant_idx = '0;
      wb_wa     = '0;
      for (int i = 0; i < NUM_MCU; i++) begin
         unit_busy[i] = (unit_state[i] != UNIT_IDLE);
         if (!RegWriteW && UnitDone[i] && unit_busy[i] && (grant_vec == '0)) begin
            grant_vec[i] = 1'b1;
            grant_idx    = OWN_W'(i);
            wb_wa        = unit_wa[i];
         end
      end
   end

   // Hazard detection, stalls, flushes and dispatch acceptance
   always_comb begin
      ldrstall    = ((RA1D == WA3E) || (RA2D == WA3E)) && MemtoRegE && RegWriteE;
      sbstall     = pend_rd(pending_q, RA1D) || pend_rd(pending_q, RA2D) ||
                    (RegWriteD && pend_rd(pending_q, WA3D)) || |(start_sel & unit_busy);
      StallF      = ldrstall || sbstall || CacheStall;
      StallD      = ldrstall || sbstall || CacheStall;
      StallE      = CacheStall;
      StallM      = CacheStall;
      FlushD      = PCSrcE;
      FlushE      = PCSrcE || ((ldrstall || sbstall) && !CacheStall);
      dispatch_ok = (|UnitStartD) && RegWriteD && !StallD && !FlushD;
      unit_start  = dispatch_ok ? start_sel : '0;
   end

   // Scoreboard next state: grant clears first so a same-cycle dispatch set wins
   always_comb begin
      pending_d = pending_q;
      owner_d   = owner_q;
      if ((|grant_vec) && (int'(wb_wa) < NUM_REGS) && (owner_q[wb_wa] == grant_idx)) begin
         pending_d[wb_wa] = 1'b0;
      end
      if (dispatch_ok && (int'(WA3D) < NUM_REGS)) begin
         pending_d[WA3D] = 1'b1;
         owner_d[WA3D]   = start_idx;
      end
   end

   // Scoreboard flops
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pending_q <= '0;
         for (int r = 0; r < NUM_REGS; r++) owner_q[r] <= '0;
      end else begin
         pending_q <= pending_d;
         for (int r = 0; r < NUM_REGS; r++) owner_q[r] <= owner_d[r];
      end
   end

   for (genvar g = 0; g < NUM_MCU; g++) begin : g_unit
      hazard_unit_fsm #(
         .ADDR_W (ADDR_W)
      ) u_fsm (
         .clk   (CLK),
         .reset (RESET),
         .start (unit_start[g]),
         .done  (UnitDone[g]),
         .grant (grant_vec[g]),
         .wa_in (WA3D),
         .state (unit_state[g]),
         .wa    (unit_wa[g])
      );
   end

   assign UnitGrant   = grant_vec;
   assign UnitWbValid = |grant_vec;
   assign UnitWbWA    = wb_wa;
   assign SbPending   = pending_q;

`ifdef HAZARD_SB_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Saturating stall/flush cycle counters
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (StallD && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (FlushE && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
   end

   // Counter flops
   always_ff @(posedge CLK) begin
      if (RESET) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
`else
   assign StallCnt = '0;
   assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: the driver pushes hand-computed
// expected outputs per cycle, a monitor pops and compares at the negedge.
module tb_hazard_scoreboard;

   localparam int W = 98;

   logic        clk = 1'b0;
   logic        RESET;
   logic [3:0]  RA1D, RA2D, WA3D, RA1E, RA2E, RA2M, WA3E, WA3M, WA3W;
   logic        RegWriteD, RegWriteE, RegWriteM, RegWriteW;
   logic        MemtoRegE, MemtoRegW, MemWriteM, PCSrcE, CacheStall;
   logic [1:0]  UnitStartD, UnitDone;
   logic [1:0]  UnitGrant;
   logic        UnitWbValid;
   logic [3:0]  UnitWbWA;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        ForwardM, StallF, StallD, StallE, StallM, FlushD, FlushE;
   logic [15:0] SbPending;
   logic [31:0] StallCnt, FlushCnt;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] msk_q[$];
   string        name_q[$];
   int           n_checks = 0;
   int           n_errors = 0;
   logic [31:0]  exp_sc = '0;
   logic [31:0]  exp_fc = '0;

   hazard_scoreboard dut (
      .CLK(clk), .RESET(RESET),
      .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D), .RA1E(RA1E), .RA2E(RA2E),
      .RA2M(RA2M), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .RegWriteD(RegWriteD), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .MemtoRegW(MemtoRegW),
      .MemWriteM(MemWriteM), .PCSrcE(PCSrcE), .CacheStall(CacheStall),
      .UnitStartD(UnitStartD), .UnitDone(UnitDone), .UnitGrant(UnitGrant),
      .UnitWbValid(UnitWbValid), .UnitWbWA(UnitWbWA),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardM(ForwardM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .SbPending(SbPending),
      .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   // Clock
   always #5 clk = ~clk;

   // Drive every input to its idle value
   task automatic clr();
      RESET = 1'b0;
      RA1D = '0; RA2D = '0; WA3D = '0; RA1E = '0; RA2E = '0; RA2M = '0;
      WA3E = '0; WA3M = '0; WA3W = '0;
      RegWriteD = 1'b0; RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      MemtoRegE = 1'b0; MemtoRegW = 1'b0; MemWriteM = 1'b0;
      PCSrcE = 1'b0; CacheStall = 1'b0;
      UnitStartD = '0; UnitDone = '0;
   endtask

   // One unchecked reset cycle
   task automatic rst_cycle();
      RESET = 1'b1;
      @(posedge clk); #1;
      RESET = 1'b0;
      exp_sc = '0;
      exp_fc = '0;
   endtask

   // Queue the expected outputs for the current cycle, then advance a cycle
   task automatic chk(input string nm, input logic [1:0] fae, input logic [1:0] fbe,
                      input logic fm, input logic sfd, input logic sem, input logic fld,
                      input logic fle, input logic [1:0] gnt, input logic [3:0] wa,
                      input logic [15:0] pend);
      logic [W-1:0] e, m;
      e = {fae, fbe, fm, sfd, sfd, sem, sem, fld, fle, gnt, |gnt, wa, pend, exp_sc, exp_fc};
      m = '1;
      if (gnt == 2'b00) m[83:80] = 4'h0;
      exp_q.push_back(e);
      msk_q.push_back(m);
      name_q.push_back(nm);
`ifdef HAZARD_SB_PERF_EN
      if (sfd) exp_sc = exp_sc + 32'd1;
      if (fle) exp_fc = exp_fc + 32'd1;
`endif
      @(posedge clk); #1;
   endtask

   // Monitor: compare DUT outputs against the queued expectation
   always @(negedge clk) begin
      logic [W-1:0] act, e, m;
      string nm;
      if (exp_q.size() != 0) begin
         e   = exp_q.pop_front();
         m   = msk_q.pop_front();
         nm  = name_q.pop_front();
         act = {ForwardAE, ForwardBE, ForwardM, StallF, StallD, StallE, StallM, FlushD,
                FlushE, UnitGrant, UnitWbValid, UnitWbWA, SbPending, StallCnt, FlushCnt};
         n_checks++;
         if ((act & m) !== (e & m)) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h mask=%h", nm, act, e, m);
         end
      end
   end

   // Stimulus
   initial begin
      clr();
      RESET = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      RESET = 1'b0;

      //        name        fae    fbe    fm  sfd sem fld fle gnt   wa    pend
      clr(); chk("rst_state", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);

      // Forwarding
      clr(); RA1E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1;
      chk("fwd_m_prio", 2'b10, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);
      clr(); RA1E = 3; RA2E = 3; WA3M = 3; WA3W = 3; RegWriteW = 1;
      chk("fwd_w", 2'b01, 2'b01, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);
      clr(); RA1E = 5; RA2E = 4; WA3M = 4; RegWriteM = 1; WA3W = 5; RegWriteW = 1;
      chk("fwd_split", 2'b01, 2'b10, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);
      clr(); RA2M = 6; WA3W = 6; MemWriteM = 1; MemtoRegW = 1; RegWriteW = 1;
      chk("fwd_mem", 2'b00, 2'b00, 1, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);
      clr(); RA2M = 6; WA3W = 6; MemWriteM = 1; RegWriteW = 1;
      chk("fwd_mem_no", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);

      // Load-use stall
      clr(); RA1D = 2; WA3E = 2; MemtoRegE = 1; RegWriteE = 1;
      chk("ldr_ra1", 2'b00, 2'b00, 0, 1, 0, 0, 1, 2'b00, 4'd0, 16'h0000);
      clr(); chk("ldr_gone", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);
      clr(); RA2D = 2; WA3E = 2; MemtoRegE = 1; RegWriteE = 1;
      chk("ldr_ra2", 2'b00, 2'b00, 0, 1, 0, 0, 1, 2'b00, 4'd0, 16'h0000);
      clr(); RA1D = 2; WA3E = 2; MemtoRegE = 1;
      chk("ldr_nowr", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);

      // MUL R5 on unit 0, dependent reader stalls until grant
      clr(); UnitStartD = 2'b01; RegWriteD = 1; WA3D = 5; RA1D = 1; RA2D = 2;
      chk("mul_disp", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);
      clr(); RA1D = 5;
      chk("mul_dep1", 2'b00, 2'b00, 0, 1, 0, 0, 1, 2'b00, 4'd0, 16'h0020);
      clr(); RA1D = 5;
      chk("mul_dep2", 2'b00, 2'b00, 0, 1, 0, 0, 1, 2'b00, 4'd0, 16'h0020);
      clr(); RA1D = 5; UnitDone = 2'b01;
      chk("mul_grant", 2'b00, 2'b00, 0, 1, 0, 0, 1, 2'b01, 4'd5, 16'h0020);
      clr(); RA1D = 5;
      chk("mul_free", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);

      // Grant held off by W-stage write, unit waits
      clr(); UnitStartD = 2'b01; RegWriteD = 1; WA3D = 9;
      chk("wait_disp", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);
      clr(); UnitDone = 2'b01; RegWriteW = 1; WA3W = 15;
      chk("wait_block", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0200);
      clr(); UnitDone = 2'b01;
      chk("wait_grant", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b01, 4'd9, 16'h0200);

      // Both units done together
      clr(); UnitStartD = 2'b01; RegWriteD = 1; WA3D = 10;
      chk("dual_d0", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);
      clr(); UnitStartD = 2'b10; RegWriteD = 1; WA3D = 11;
      chk("dual_d1", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0400);
      clr(); UnitDone = 2'b11;
      chk("dual_g0", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b01, 4'd10, 16'h0C00);
      clr(); UnitDone = 2'b10;
      chk("dual_g1", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b10, 4'd11, 16'h0800);
      clr(); chk("dual_idle", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);

      // Two start bits: only unit 0 takes it; dispatch to busy unit stalls
      clr(); UnitStartD = 2'b11; RegWriteD = 1; WA3D = 13;
      chk("pri_disp", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);
      clr(); UnitStartD = 2'b01; RegWriteD = 1; WA3D = 14;
      chk("pri_busy", 2'b00, 2'b00, 0, 1, 0, 0, 1, 2'b00, 4'd0, 16'h2000);
      clr(); UnitDone = 2'b01;
      chk("pri_grant", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b01, 4'd13, 16'h2000);
      clr(); UnitStartD = 2'b10; RegWriteD = 1; WA3D = 7;
      chk("u1_disp", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);

      // Reset with unit 1 busy on R7
      clr(); rst_cycle();
      clr(); UnitDone = 2'b10; RA1D = 7;
      chk("rst_mid", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);

      // Cache stall for three cycles, then counters
      clr(); CacheStall = 1;
      chk("cs_1", 2'b00, 2'b00, 0, 1, 1, 0, 0, 2'b00, 4'd0, 16'h0000);
      clr(); CacheStall = 1;
      chk("cs_2", 2'b00, 2'b00, 0, 1, 1, 0, 0, 2'b00, 4'd0, 16'h0000);
      clr(); CacheStall = 1;
      chk("cs_3", 2'b00, 2'b00, 0, 1, 1, 0, 0, 2'b00, 4'd0, 16'h0000);
      clr(); chk("cs_cnt", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);

      // Flushes
      clr(); PCSrcE = 1;
      chk("flush_br", 2'b00, 2'b00, 0, 0, 0, 1, 1, 2'b00, 4'd0, 16'h0000);
      clr(); CacheStall = 1; RA1D = 2; WA3E = 2; MemtoRegE = 1; RegWriteE = 1;
      chk("ldr_cs", 2'b00, 2'b00, 0, 1, 1, 0, 0, 2'b00, 4'd0, 16'h0000);
      clr(); UnitStartD = 2'b01; RegWriteD = 1; WA3D = 4; PCSrcE = 1;
      chk("disp_flushed", 2'b00, 2'b00, 0, 0, 0, 1, 1, 2'b00, 4'd0, 16'h0000);
      clr(); chk("no_pend", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'd0, 16'h0000);

      // Let the monitor drain, bounded
      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
